// File: rtl/tile_row_scroller_pkg.sv
// rtl/tile_row_scroller_pkg.sv - lane codes, FSM states and the new-row code mapping
package tile_row_scroller_pkg;

    localparam int LANE_W = 3;

    localparam logic [LANE_W-1:0] LANE_NONE = 3'b000;
    localparam logic [LANE_W-1:0] LANE_K3   = 3'b001;
    localparam logic [LANE_W-1:0] LANE_K2   = 3'b010;
    localparam logic [LANE_W-1:0] LANE_K1   = 3'b011;
    localparam logic [LANE_W-1:0] LANE_K0   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    // Top two bits zero leave the row empty; otherwise the low bits pick a key lane.
    function automatic logic [LANE_W-1:0] lane_code(input logic [7:0] lfsr);
        logic [LANE_W-1:0] code;
        code = LANE_NONE;
        if (lfsr[7:6] != 2'b00) begin
            case (lfsr[1:0])
                2'b00:   code = LANE_K3;
                2'b01:   code = LANE_K2;
                2'b10:   code = LANE_K1;
                default: code = LANE_K0;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/tile_row_scroller_lfsr.sv
// rtl/tile_row_scroller_lfsr.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) producing the next row code
module tile_lfsr
    import tile_row_scroller_pkg::*;
#(
    parameter logic [7:0] RESET_SEED = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [7:0]        seed,
    output logic [LANE_W-1:0] code
);

    logic [7:0] lfsr;
    logic       feedback;

    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign code     = lane_code(lfsr);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= RESET_SEED;
        end else if (load) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

endmodule

// File: rtl/tile_row_scroller.sv
// rtl/tile_row_scroller.sv - scrolling tile field, checker handshake, score and lives
module tile_row_scroller
    import tile_row_scroller_pkg::*;
#(
    parameter int         NUM_LINES = 7,
    parameter int         SCORE_W   = 8,
    parameter int         LIVES     = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        step,
    input  logic                        check_input_done,
    input  logic                        correct,
    input  logic                        incorrect,
    output logic                        check_input_go,
    output logic [LANE_W*NUM_LINES-1:0] lines,
    output logic [LANE_W-1:0]           line_6,
    output logic [SCORE_W-1:0]          score,
    output logic [2:0]                  lives,
    output logic                        game_over
);

    state_t            state, state_next;
    logic [LANE_W-1:0] rows [NUM_LINES];
    logic [LANE_W-1:0] new_code;
    logic              go_hold;
    logic              do_start, do_scroll, do_hit, do_dec;

    tile_lfsr #(.RESET_SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (do_start),
        .advance (do_scroll),
        .seed    (LFSR_SEED),
        .code    (new_code)
    );

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_scroll  = 1'b0;
        do_hit     = 1'b0;
        do_dec     = 1'b0;
        case (state)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (check_input_done) begin
                    if (correct) do_hit = 1'b1;
                    else if (incorrect) do_dec = 1'b1;
                    state_next = ST_WAIT;
                end
                // A step overrides the WAIT hand-off; a miss only counts when no result arrived.
                if (step) begin
                    do_scroll  = 1'b1;
                    state_next = ST_ARMED;
                    if (!check_input_done && rows[NUM_LINES-1] != LANE_NONE) do_dec = 1'b1;
                end
                if (do_dec && lives == 3'd1) state_next = ST_GAMEOVER;
            end
            ST_WAIT: begin
                if (step) begin
                    do_scroll  = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            go_hold <= 1'b0;
            score   <= '0;
            lives   <= 3'(LIVES);
            for (int k = 0; k < NUM_LINES; k++) rows[k] <= LANE_NONE;
        end else begin
            state   <= state_next;
            go_hold <= do_scroll;
            if (do_start) begin
                score <= '0;
                lives <= 3'(LIVES);
                for (int k = 0; k < NUM_LINES; k++) rows[k] <= LANE_NONE;
            end else begin
                if (do_hit && score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
                if (do_dec && lives != 3'd0) lives <= lives - 3'd1;
                if (do_hit) rows[NUM_LINES-1] <= LANE_NONE;
                if (do_scroll) begin
                    for (int k = 1; k < NUM_LINES; k++) rows[k] <= rows[k-1];
                    rows[0] <= new_code;
                end
            end
        end
    end

    always_comb begin
        lines = '0;
        for (int k = 0; k < NUM_LINES; k++) lines[LANE_W*k +: LANE_W] = rows[k];
    end

    assign line_6         = rows[NUM_LINES-1];
    assign check_input_go = (state == ST_ARMED) && !go_hold;
    assign game_over      = (state == ST_GAMEOVER);

endmodule

// File: tb/tb_tile_row_scroller.sv
// tb/tb_tile_row_scroller.sv - directed self-checking bench for tile_row_scroller
module tb_tile_row_scroller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        check_input_done = 1'b0;
    logic        correct = 1'b0;
    logic        incorrect = 1'b0;
    logic        check_input_go;
    logic [20:0] lines;
    logic [2:0]  line_6;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        game_over;

    int n_checks = 0;
    int n_errors = 0;

    // Codes for seed A5: c0..c11 = 010 011 010 000 001 010 100 100 011 010 000 100
    localparam logic [20:0] LINES_AFTER_7  = 21'b010_011_010_000_001_010_100;
    localparam logic [20:0] LINES_AFTER_12 = 21'b010_100_100_011_010_000_100;
    localparam logic [20:0] LINES_AFTER_2  = 21'b000_000_000_000_000_010_011;

    tile_row_scroller dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .step             (step),
        .check_input_done (check_input_done),
        .correct          (correct),
        .incorrect        (incorrect),
        .check_input_go   (check_input_go),
        .lines            (lines),
        .line_6           (line_6),
        .score            (score),
        .lives            (lives),
        .game_over        (game_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_done(input logic ok, input logic with_step);
        check_input_done = 1'b1;
        correct          = ok;
        incorrect        = !ok;
        step             = with_step;
        tick();
        check_input_done = 1'b0;
        correct          = 1'b0;
        incorrect        = 1'b0;
        step             = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_go", 32'(check_input_go), 32'd0);
        check("rst_gameover", 32'(game_over), 32'd0);
        check("rst_lines", 32'(lines), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);

        do_start();
        check("start_go", 32'(check_input_go), 32'd1);
        check("start_lives", 32'(lives), 32'd3);
        check("start_lines", 32'(lines), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_step();
            if (i == 0) begin
                check("step_go_low", 32'(check_input_go), 32'd0);
                check("first_row0", 32'(lines[2:0]), 32'b010);
            end
            tick();
            if (i == 0) check("step_go_back", 32'(check_input_go), 32'd1);
        end
        check("fill_line6", 32'(line_6), 32'b010);
        check("fill_lines", 32'(lines), 32'(LINES_AFTER_7));
        check("fill_lives", 32'(lives), 32'd3);

        do_done(1'b1, 1'b0);
        check("hit_score", 32'(score), 32'd1);
        check("hit_line6", 32'(line_6), 32'b000);
        check("hit_go", 32'(check_input_go), 32'd0);
        tick();
        check("wait_go", 32'(check_input_go), 32'd0);
        do_step();
        check("wait_step_line6", 32'(line_6), 32'b011);
        check("wait_step_go", 32'(check_input_go), 32'd0);
        tick();
        check("rearm_go", 32'(check_input_go), 32'd1);

        do_step();
        check("miss_lives", 32'(lives), 32'd2);
        check("miss_line6", 32'(line_6), 32'b010);
        check("miss_go_low", 32'(check_input_go), 32'd0);
        tick();
        check("miss_go_back", 32'(check_input_go), 32'd1);

        do_done(1'b1, 1'b1);
        check("both_score", 32'(score), 32'd2);
        check("both_lives", 32'(lives), 32'd2);
        check("both_line6", 32'(line_6), 32'b000);
        check("both_go", 32'(check_input_go), 32'd0);
        tick();
        check("both_go_back", 32'(check_input_go), 32'd1);

        do_step();
        check("empty_nomiss", 32'(lives), 32'd2);
        check("empty_line6", 32'(line_6), 32'b001);
        tick();

        do_done(1'b0, 1'b0);
        check("bad1_lives", 32'(lives), 32'd1);
        check("bad1_line6", 32'(line_6), 32'b001);
        do_step();
        tick();
        do_done(1'b0, 1'b0);
        check("bad2_lives", 32'(lives), 32'd0);
        check("bad2_gameover", 32'(game_over), 32'd1);
        check("bad2_go", 32'(check_input_go), 32'd0);
        do_step();
        tick();
        check("go_frozen_lines", 32'(lines), 32'(LINES_AFTER_12));
        check("go_frozen_score", 32'(score), 32'd2);

        do_start();
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_score", 32'(score), 32'd0);
        check("restart_gameover", 32'(game_over), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_done(1'b0, 1'b0);
            check("triple_lives", 32'(lives), 32'(2 - i));
            if (i < 2) begin
                do_step();
                tick();
            end
        end
        check("triple_gameover", 32'(game_over), 32'd1);
        do_step();
        do_step();
        check("triple_frozen", 32'(lines), 32'(LINES_AFTER_2));
        do_start();
        check("restart2_lives", 32'(lives), 32'd3);
        check("restart2_score", 32'(score), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_done(1'b1, 1'b0);
            do_step();
            tick();
        end
        check("five_score", 32'(score), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_score", 32'(score), 32'd0);
        check("midrst_lines", 32'(lines), 32'd0);
        check("midrst_go", 32'(check_input_go), 32'd0);
        tick();
        check("midrst_idle_go", 32'(check_input_go), 32'd0);

        do_start();
        for (int i = 0; i < 255; i++) begin
            do_done(1'b1, 1'b0);
            do_step();
            tick();
        end
        check("sat_reach", 32'(score), 32'hFF);
        do_done(1'b1, 1'b0);
        check("sat_hold", 32'(score), 32'hFF);
        check("sat_lives", 32'(lives), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_row_scroller.md
Name: tile_row_scroller

Overview:
- Producer/consumer on the other side of the key-check interface.
- Owns the 7-row tile field. Generates new rows pseudo-randomly and scrolls them down one row per step tick.
- Presents the bottom row (line_6) to the key checker and drives check_input_go.
- Consumes check_input_done/correct/incorrect to update score and lives, and declares game over.

Parameters:
- NUM_LINES, 7, rows in the field; row NUM_LINES-1 is the hit row.
- SCORE_W, 8, score width; score saturates at all-ones.
- LIVES, 3, lives loaded at start (1..7).
- LFSR_SEED, 8'hA5, nonzero LFSR reset/start value.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; overrides all other inputs.
- start  in  1  level; sampled in IDLE/GAMEOVER to begin a game.
- step  in  1  one-cycle scroll tick from the rate divider.
- check_input_done  in  1  checker finished evaluating line_6.
- correct  in  1  checker: right key pressed (valid with done).
- incorrect  in  1  checker: wrong key pressed (valid with done).
- check_input_go  out  1  arms checker; low clears checker.
- lines  out  3*NUM_LINES  row k at bits [3k+2:3k]; lane code 000 empty, 001..100 = key3..key0.
- line_6  out  3  alias of row NUM_LINES-1.
- score  out  SCORE_W  hits this game.
- lives  out  3  remaining lives.
- game_over  out  1  high in GAMEOVER.

Behaviour:
- Reset values:
  - all rows 000; score 0; lives LIVES.
  - check_input_go 0; game_over 0.
  - LFSR LFSR_SEED; state IDLE.
- States: IDLE, ARMED, WAIT, GAMEOVER.
- IDLE: go=0, rows held.
  - start=1 -> clear rows, score 0, lives LIVES, LFSR reseeded; next state ARMED.
- ARMED: go=1.
  - done=1 & correct=1 -> score+1 (saturating), row 6 cleared to 000 (no double scoring).
  - done=1 & incorrect=1 -> lives-1; row 6 unchanged.
  - In both done cases: next state WAIT.
  - step=1 & done=0:
    - line_6 != 000 -> miss, lives-1.
    - Scroll, stay ARMED with go forced low for that one cycle.
  - step=1 & done=1 same cycle: done result applied, scroll applied, miss NOT counted, next ARMED with go low one cycle.
- WAIT: go=0 (checker clears its outputs). step=1 -> scroll, next ARMED.
- Scroll, one clock:
  - row k <= row k-1 for k = 1..NUM_LINES-1.
  - row 0 <= new code; LFSR advances once.
  - Result visible the cycle after step; go re-asserts the cycle after that.
- New code:
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4, shifts only on scroll.
  - If lfsr[7:6]==00, code 000.
  - Otherwise code = {1'b0, lfsr[1:0]} + 1, giving 001..100.
  - Codes 101..111 are never generated.
- Lives:
  - A decrement that reaches 0 -> GAMEOVER on the next edge; the same edge applies the pending scroll, if any.
  - Lives never underflow; a decrement at 0 is ignored.
- GAMEOVER:
  - game_over=1, go=0; rows, score and lives frozen; step ignored.
  - start=1 -> same as start from IDLE.
- done while in WAIT/IDLE/GAMEOVER is ignored.
- Reset mid-game: same as reset values, same edge; no score or lives update from that cycle.

Decomposition:
- Shared package:
  - lane codes LANE_NONE=3'b000, LANE_K3=3'b001, LANE_K2=3'b010, LANE_K1=3'b011, LANE_K0=3'b100.
  - state encoding.
  - LANE_W=3.
- One sub-module: tile_lfsr.
  - Ports: clock, reset, load, advance, seed, code[2:0].
  - Contains the LFSR and the code mapping.

Test Plan:
- Reset then start=1:
  - Next cycle state ARMED: go=1, lives=3, score=0, lines=0.
  - 7 steps later row 6 holds the first generated code for seed A5.
- line_6=010, done=1 & correct=1 in ARMED -> score 0->1, line_6 000 next edge, go=0 until next step.
- line_6=001, no done, step=1 -> lives 3->2; rows shift; go low exactly one cycle.
- step and done/correct same cycle with line_6=100 -> score+1, lives unchanged, shift occurs.
- Three incorrect in successive windows:
  - lives 3,2,1,0.
  - game_over=1 the next cycle.
  - further steps leave lines unchanged.
  - start restarts with lives=3, score=0.
- Reset asserted in ARMED with score=5 -> next edge: score=0, lines=0, go=0, IDLE.
- score at 8'hFF plus correct -> remains 8'hFF.
